// File: rtl/ddc_qam_demap_pkg.sv
// Shared types and the per-axis level-to-Gray demapper for the QAM demap path.
package ddc_demap_pkg;

  typedef logic signed [7:0] level_t;
  typedef logic [5:0]        sym_t;

  localparam int BITS_PER_AXIS = 3;

  // One demapped axis: Gray code plus "value was not a legal level" flag.
  typedef struct packed {
    logic [BITS_PER_AXIS-1:0] gray;
    logic                     err;
  } demap_t;

  // One joined input beat as seen by the packer.
  typedef struct packed {
    logic keep;   // beat sits on the kept decimation phase
    logic last;   // frame end (taken from the I channel)
    sym_t sym;    // {gray_I, gray_Q}
  } beat_t;

  // Map an 8-level axis value to its 3-bit Gray code. Even values sit exactly
  // between two legal levels and round upwards (so 0 decodes as +1); values
  // beyond +/-7 clamp to the outermost level. Both cases raise err.
  function automatic demap_t level2gray(level_t v);
    demap_t     r;
    logic       even;
    logic [8:0] t;
    logic [2:0] k;
    even = ~v[0];
    t    = {v[7], v} + 9'd7 + 9'(even);
    if (v > 8'sd7)       k = 3'd7;
    else if (v < -8'sd7) k = 3'd0;
    else                 k = t[3:1];
    r.gray = k ^ (k >> 1);
    r.err  = even | (v > 8'sd7) | (v < -8'sd7);
    return r;
  endfunction

endpackage

// File: rtl/ddc_qam_demap_if.sv
// 8-bit AXI-Stream channel used for the I/Q inputs and the packed byte output.
interface ddc_qam_demap_if;
  logic       tvalid;
  logic       tready;
  logic       tlast;
  logic [7:0] tdata;

  modport master (output tvalid, tdata, tlast, input tready);
  modport slave  (input tvalid, tdata, tlast, output tready);
endinterface

// File: rtl/ddc_qam_demap_byte_packer.sv
// Packs 6-bit symbols MSB-first into a 24-bit group, commits groups/partial
// groups into a 3-byte output buffer and drives the byte AXIS master.
module ddc_byte_packer
  import ddc_demap_pkg::*;
(
  input  logic  aclk,
  input  logic  reset,
  input  logic  pend,    // both input channels valid this cycle
  input  beat_t beat,
  output logic  stall,
  ddc_qam_demap_if.master m
);

  logic [23:0] acc, acc_nx, acc_sum, ins;
  logic [2:0]  cnt, cnt_nx, cnt_sum;
  logic [23:0] obuf;
  logic [1:0]  ocnt;
  logic        olast;

  logic        obuf_free, preflush, commit_req, take;
  logic        load, ld_last;
  logic [23:0] ld_data;
  logic [1:0]  ld_cnt;

  assign m.tvalid = (ocnt != 2'd0);
  assign m.tdata  = obuf[23:16];
  assign m.tlast  = olast & (ocnt == 2'd1);

  // Commit decision, stall generation and next accumulator contents.
  always_comb begin
    load    = 1'b0;
    ld_data = acc;
    ld_cnt  = 2'd3;
    ld_last = 1'b0;
    acc_nx  = acc;
    cnt_nx  = cnt;
    ins     = '0;

    // The buffer can take a commit if empty or handing over its final byte now.
    obuf_free = (ocnt == 2'd0) | ((ocnt == 2'd1) & m.tready);

    case (cnt)
      3'd0:    ins = {beat.sym, 18'd0};
      3'd1:    ins = {6'd0, beat.sym, 12'd0};
      3'd2:    ins = {12'd0, beat.sym, 6'd0};
      3'd3:    ins = {18'd0, beat.sym};
      default: ins = '0;
    endcase
    acc_sum = beat.keep ? (acc | ins) : acc;
    cnt_sum = cnt + 3'(beat.keep);

    // A kept tlast symbol on a full group needs two commits; flush the held
    // group first while holding the beat, then take the beat as count 0.
    preflush   = pend & beat.keep & beat.last & (cnt == 3'd4);
    commit_req = pend & ~preflush &
                 ((beat.keep & (cnt == 3'd4)) | (beat.last & (cnt_sum != 3'd0)));
    stall      = preflush | (commit_req & ~obuf_free);
    take       = pend & ~stall;

    if (preflush & obuf_free) begin
      load   = 1'b1;
      acc_nx = '0;
      cnt_nx = 3'd0;
    end else if (take) begin
      if (beat.keep & (cnt == 3'd4)) begin
        load   = 1'b1;
        acc_nx = {beat.sym, 18'd0};
        cnt_nx = 3'd1;
      end else if (beat.last) begin
        load    = (cnt_sum != 3'd0);
        ld_data = acc_sum;
        ld_last = 1'b1;
        case (cnt_sum)
          3'd1:    ld_cnt = 2'd1;
          3'd2:    ld_cnt = 2'd2;
          default: ld_cnt = 2'd3;
        endcase
        acc_nx = '0;
        cnt_nx = 3'd0;
      end else begin
        acc_nx = acc_sum;
        cnt_nx = cnt_sum;
      end
    end
  end

  // Symbol accumulator state.
  always_ff @(posedge aclk) begin
    if (reset) begin
      acc <= '0;
      cnt <= '0;
    end else begin
      acc <= acc_nx;
      cnt <= cnt_nx;
    end
  end

  // Output buffer: load on commit, otherwise shift out one byte per handshake.
  always_ff @(posedge aclk) begin
    if (reset) begin
      obuf  <= '0;
      ocnt  <= '0;
      olast <= 1'b0;
    end else if (load) begin
      obuf  <= ld_data;
      ocnt  <= ld_cnt;
      olast <= ld_last;
    end else if (m.tvalid & m.tready) begin
      obuf <= {obuf[15:0], 8'd0};
      ocnt <= ocnt - 2'd1;
      if (ocnt == 2'd1) olast <= 1'b0;
    end
  end

endmodule

// File: rtl/ddc_qam_demap.sv
// Joins the I/Q sample streams, decimates, demaps each axis to Gray bits and
// hands the symbols to the byte packer.
module ddc_qam_demap
  import ddc_demap_pkg::*;
#(
  parameter int DECIM      = 2,
  parameter int KEEP_PHASE = 1
) (
  input  logic        aclk,
  input  logic        reset,
  ddc_qam_demap_if.slave  s_i,
  ddc_qam_demap_if.slave  s_q,
  ddc_qam_demap_if.master m,
  output logic [15:0] frame_cnt,
  output logic        err_level,
  output logic        err_last
);

  localparam int             PW      = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam logic [PW-1:0]  KEEP_PH = PW'(KEEP_PHASE);
  localparam logic [PW-1:0]  LAST_PH = PW'(DECIM - 1);

  logic [PW-1:0] phase;
  logic          pend, stall, accept;
  demap_t        dm_i, dm_q;
  beat_t         beat;

  // Ready is withheld while in reset so nothing is consumed during it.
  assign pend       = s_i.tvalid & s_q.tvalid & ~reset;
  assign accept     = pend & ~stall;
  assign s_i.tready = accept;
  assign s_q.tready = accept;

  assign dm_i = level2gray(level_t'(s_i.tdata));
  assign dm_q = level2gray(level_t'(s_q.tdata));

  // Present the candidate beat to the packer; it decides whether to stall.
  always_comb begin
    beat.keep = (phase == KEEP_PH);
    beat.last = s_i.tlast;
    beat.sym  = {dm_i.gray, dm_q.gray};
  end

  // Decimation phase: advances per accepted beat, restarts after a frame end.
  always_ff @(posedge aclk) begin
    if (reset)
      phase <= '0;
    else if (accept)
      phase <= (s_i.tlast || phase == LAST_PH) ? '0 : phase + 1'b1;
  end

  // Frame counter and sticky error flags.
  always_ff @(posedge aclk) begin
    if (reset) begin
      frame_cnt <= '0;
      err_level <= 1'b0;
      err_last  <= 1'b0;
    end else if (accept) begin
      if (s_i.tlast) frame_cnt <= frame_cnt + 16'd1;
      if (beat.keep & (dm_i.err | dm_q.err)) err_level <= 1'b1;
      if (s_i.tlast ^ s_q.tlast) err_last <= 1'b1;
    end
  end

  ddc_byte_packer u_pack (
    .aclk  (aclk),
    .reset (reset),
    .pend  (pend),
    .beat  (beat),
    .stall (stall),
    .m     (m)
  );

endmodule

// File: tb/tb_ddc_qam_demap.sv
// Directed + randomized bench for ddc_qam_demap against a bit-queue reference.
module tb_ddc_qam_demap;

  localparam int DECIM = 2;
  localparam int KEEP  = 1;

  logic        aclk  = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] frame_cnt;
  logic        err_level, err_last;

  ddc_qam_demap_if s_i_if ();
  ddc_qam_demap_if s_q_if ();
  ddc_qam_demap_if m_if ();

  ddc_qam_demap #(.DECIM(DECIM), .KEEP_PHASE(KEEP)) dut (
    .aclk      (aclk),
    .reset     (reset),
    .s_i       (s_i_if),
    .s_q       (s_q_if),
    .m         (m_if),
    .frame_cnt (frame_cnt),
    .err_level (err_level),
    .err_last  (err_last)
  );

  always #5 aclk = ~aclk;

  typedef struct { int i; int q; bit li; bit lq; } beat_s;
  typedef struct { bit [7:0] d; bit l; } obyte_s;

  beat_s  bq[$];
  obyte_s got[$], exp_q[$], ref1[$];
  int     n_cmp = 0, n_err = 0;
  int     exp_frames = 0, in_cycles = 0;
  bit     exp_elev = 0, exp_elast = 0, join_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  // Capture every byte that will transfer on the coming rising edge.
  always @(negedge aclk)
    if (!reset && m_if.tvalid && m_if.tready) got.push_back('{m_if.tdata, m_if.tlast});

  // Nearest legal level, ties resolved upwards, out-of-range clamped.
  function automatic int ref_level(int v);
    int best = -7, bd = 1000;
    for (int l = -7; l <= 7; l += 2) begin
      int d = (v > l) ? v - l : l - v;
      if (d <= bd) begin best = l; bd = d; end
    end
    return best;
  endfunction

  function automatic bit [2:0] gray_of(int l);
    case (l)
      -7: return 3'b000;  -5: return 3'b001;  -3: return 3'b011;  -1: return 3'b010;
       1: return 3'b110;   3: return 3'b111;   5: return 3'b101;   7: return 3'b100;
      default: return 3'b000;
    endcase
  endfunction

  function automatic bit legal(int v);
    return (v >= -7) && (v <= 7) && ((v & 1) == 1);
  endfunction

  function automatic int rnd_lvl();
    return int'($urandom_range(7)) * 2 - 7;
  endfunction

  // Reference: per frame, kept symbols become a flat bit stream, zero-padded
  // to a byte boundary at frame end and cut into bytes.
  task automatic model();
    bit bits[$];
    int ph = 0;
    exp_q.delete();
    foreach (bq[x]) begin
      if ((ph % DECIM) == KEEP) begin
        bit [2:0] gi = gray_of(ref_level(bq[x].i));
        bit [2:0] gq = gray_of(ref_level(bq[x].q));
        for (int b = 2; b >= 0; b--) bits.push_back(gi[b]);
        for (int b = 2; b >= 0; b--) bits.push_back(gq[b]);
        if (!legal(bq[x].i) || !legal(bq[x].q)) exp_elev = 1;
      end
      if (bq[x].li != bq[x].lq) exp_elast = 1;
      if (bq[x].li) begin
        while (bits.size() % 8 != 0) bits.push_back(1'b0);
        while (bits.size() > 0) begin
          bit [7:0] v = 8'd0;
          for (int b = 0; b < 8; b++) v = {v[6:0], bits.pop_front()};
          exp_q.push_back('{v, bits.size() == 0});
        end
        exp_frames++;
        ph = 0;
      end else ph++;
    end
  endtask

  // Stream bq with Q valid lagging by up to 'lag' cycles and random m_tready.
  task automatic drive(input int rdy_pct, input int lag, input int budget);
    int k = 0, qd = 0, cyc = 0, n = bq.size();
    bit hs;
    qd = int'($urandom_range(lag));
    while (k < n && cyc < budget) begin
      s_i_if.tvalid = 1'b1;      s_i_if.tdata = 8'(bq[k].i); s_i_if.tlast = bq[k].li;
      s_q_if.tvalid = (qd == 0); s_q_if.tdata = 8'(bq[k].q); s_q_if.tlast = bq[k].lq;
      m_if.tready = ($urandom_range(99) < rdy_pct);
      @(negedge aclk);
      if (s_i_if.tready !== s_q_if.tready ||
          (s_i_if.tready && !(s_i_if.tvalid && s_q_if.tvalid))) join_bad = 1;
      hs = s_i_if.tvalid && s_q_if.tvalid && s_i_if.tready;
      @(posedge aclk); #1;
      if (hs) begin k++; qd = int'($urandom_range(lag)); end
      else if (qd > 0) qd--;
      cyc++;
    end
    in_cycles = cyc;
    s_i_if.tvalid = 1'b0; s_q_if.tvalid = 1'b0;
    chk("inputs_consumed", k, n);
    while (got.size() < exp_q.size() && cyc < budget) begin
      m_if.tready = ($urandom_range(99) < rdy_pct);
      @(posedge aclk); #1;
      cyc++;
    end
    m_if.tready = 1'b1;
    repeat (6) @(posedge aclk);
    #1;
  endtask

  task automatic cmp_bytes(input string tag);
    chk({tag, "_nbytes"}, got.size(), exp_q.size());
    for (int x = 0; x < exp_q.size() && x < got.size(); x++) begin
      chk($sformatf("%s_byte%0d", tag, x), got[x].d, exp_q[x].d);
      chk($sformatf("%s_last%0d", tag, x), got[x].l, exp_q[x].l);
    end
    chk({tag, "_frame_cnt"}, frame_cnt, 16'(exp_frames));
    chk({tag, "_err_level"}, err_level, exp_elev);
    chk({tag, "_err_last"}, err_last, exp_elast);
    chk({tag, "_join"}, join_bad, 0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(posedge aclk);
    #1;
    reset = 1'b0;
    got.delete();
    exp_frames = 0; exp_elev = 0; exp_elast = 0;
  endtask

  initial begin
    s_i_if.tvalid = 1'b1; s_i_if.tdata = 8'd7; s_i_if.tlast = 1'b0;
    s_q_if.tvalid = 1'b1; s_q_if.tdata = 8'd7; s_q_if.tlast = 1'b0;
    m_if.tready = 1'b1;

    // Reset state, with both input valids high.
    repeat (3) @(posedge aclk);
    #1;
    chk("rst_tready_i", s_i_if.tready, 0);
    chk("rst_tready_q", s_q_if.tready, 0);
    chk("rst_m_tvalid", m_if.tvalid, 0);
    chk("rst_m_tlast", m_if.tlast, 0);
    chk("rst_m_tdata", m_if.tdata, 0);
    chk("rst_frame_cnt", frame_cnt, 0);
    chk("rst_errs", {err_level, err_last}, 0);
    s_i_if.tvalid = 1'b0; s_q_if.tvalid = 1'b0;
    reset = 1'b0;

    // Mid-frame reset: two kept symbols pending, then reset discards them.
    bq.delete();
    for (int x = 0; x < 4; x++) bq.push_back('{rnd_lvl(), rnd_lvl(), 1'b0, 1'b0});
    drive(100, 0, 200);
    chk("midrst_no_bytes", got.size(), 0);
    s_i_if.tvalid = 1'b1; s_q_if.tvalid = 1'b1;
    reset = 1'b1;
    @(posedge aclk); #1;
    chk("midrst_tready", s_i_if.tready, 0);
    chk("midrst_m_tvalid", m_if.tvalid, 0);
    chk("midrst_frame_cnt", frame_cnt, 0);
    s_i_if.tvalid = 1'b0; s_q_if.tvalid = 1'b0;
    do_reset();

    // Directed frames: map/pack, 1-symbol flush, empty frame, 5-symbol frame.
    // Dropped-phase samples are 0 to show they never raise err_level.
    bq.delete();
    bq.push_back('{0, 0, 0, 0}); bq.push_back('{-7, -7, 0, 0});
    bq.push_back('{0, 0, 0, 0}); bq.push_back('{-5,  7, 0, 0});
    bq.push_back('{0, 0, 0, 0}); bq.push_back('{ 7, -5, 0, 0});
    bq.push_back('{0, 0, 0, 0}); bq.push_back('{ 1, -1, 1, 1});
    bq.push_back('{0, 0, 0, 0}); bq.push_back('{ 3,  5, 1, 1});
    bq.push_back('{0, 0, 1, 1});
    for (int x = 0; x < 10; x++) bq.push_back('{0, rnd_lvl(), x == 9, x == 9});
    for (int x = 1; x < 10; x += 2) bq[bq.size() - 10 + x].i = rnd_lvl();
    model();
    drive(100, 0, 500);
    cmp_bytes("directed");

    // Full 680-sample frame at +7/+7: 255 bytes, no input stall at full rate.
    do_reset();
    bq.delete();
    for (int x = 0; x < 680; x++) bq.push_back('{7, 7, x == 679, x == 679});
    model();
    drive(100, 0, 2000);
    chk("full_nostall", in_cycles, 680);
    cmp_bytes("full");

    // Random legal frames: free-running run, then the same stream stalled.
    do_reset();
    bq.delete();
    for (int f = 0; f < 5; f++) begin
      int len = int'($urandom_range(60, 1));
      for (int x = 0; x < len; x++)
        bq.push_back('{rnd_lvl(), rnd_lvl(), x == len - 1, x == len - 1});
    end
    model();
    drive(100, 0, 2000);
    cmp_bytes("rand_free");
    ref1 = got;
    got.delete();
    model();
    drive(30, 3, 20000);
    cmp_bytes("rand_stall");
    chk("stall_vs_free_n", got.size(), ref1.size());
    for (int x = 0; x < got.size() && x < ref1.size(); x++)
      chk($sformatf("stall_vs_free%0d", x), {got[x].d, got[x].l}, {ref1[x].d, ref1[x].l});

    // Error handling: level 0, out-of-range/even levels, tlast disagreement.
    do_reset();
    bq.delete();
    bq.push_back('{1, 1, 0, 0}); bq.push_back('{0, -7, 1, 1});
    bq.push_back('{1, 1, 0, 0}); bq.push_back('{-100, 6, 1, 1});
    bq.push_back('{1, 1, 0, 0}); bq.push_back('{1, 1, 1, 0});
    model();
    drive(100, 0, 500);
    cmp_bytes("errors");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d compared / %0d mismatched", n_cmp, n_err);
    $fatal(1, "watchdog");
  end

endmodule
